debug_ctrl: RTL
===============

DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: instruction, PC, register and memory word width; multiple of 8.
REQ-002 SHALL have parameter NUM_REGS, default 32: registers dumped per report.
REQ-003 SHALL have parameter NUM_MEM, default 16: memory words dumped per report.
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports: i_clock, i_reset.
REQ-005 SHALL have port i_clock  in  1  system clock.
REQ-006 SHALL have port i_reset  in  1  async active-low reset.
REQ-007 SHALL have port i_rx_valid  in  1  one-cycle pulse, received byte valid.
REQ-008 SHALL have port i_rx_byte  in  8  received byte.
REQ-009 SHALL have port i_tx_done  in  1  one-cycle pulse, transmitter finished current byte.
REQ-010 SHALL have port o_tx_start  out  1  one-cycle pulse, start sending o_tx_byte.
REQ-011 SHALL have port o_tx_byte  out  8  byte to send; stable until i_tx_done.
REQ-012 SHALL have port i_finish  in  1  halt instruction reached write-back.
REQ-013 SHALL have port i_pc  in  DATA_WIDTH  current decode-stage PC.
REQ-014 SHALL have port i_reg / i_mem  in  DATA_WIDTH  word at o_reg_sel / o_mem_sel, valid one cycle after select changes.
REQ-015 SHALL have port o_reg_sel / o_mem_sel  out  clog2(NUM_REGS) / clog2(NUM_MEM)  dump index.
REQ-016 SHALL have port o_instruccion, o_address  out  DATA_WIDTH  instruction-memory load word and byte address.
REQ-017 SHALL have port o_loading, o_start, o_step, o_reg_send, o_mem_send  out  1 each  load strobe, run level, step pulse, register-dump active, memory-dump active.

Function
REQ-018 SHALL implement states IDLE, LOAD, BKPT, RUN, DUMP; all multi-byte words little-endian.
REQ-019 In IDLE SHALL decode i_rx_byte on i_rx_valid: 0x4C 'L' to LOAD; 0x5A 'Z' clears load address to 0; 0x42 'B' to BKPT; 0x43 'C' disables breakpoint; 0x52 'R' to RUN; 0x53 'S' step; any other byte ignored, stay IDLE.
REQ-020 LOAD SHALL collect DATA_WIDTH/8 bytes, then drive o_instruccion and o_address for one cycle with o_loading=1, increment load address by DATA_WIDTH/8, return to IDLE.
REQ-021 BKPT SHALL collect DATA_WIDTH/8 bytes into breakpoint register, set breakpoint-enable, return to IDLE.
REQ-022 'R' with i_finish=0 SHALL enter RUN and hold o_start=1 from next cycle; with i_finish=1 SHALL skip RUN and enter DUMP.
REQ-023 RUN SHALL exit to DUMP, o_start=0 next cycle, on first of: i_finish=1; breakpoint enabled and i_pc equals breakpoint; received byte 0x48 'H'. Other received bytes in RUN ignored.
REQ-024 'S' SHALL pulse o_step one cycle (suppressed if i_finish=1), then enter DUMP.
REQ-025 DUMP SHALL send i_pc, then registers 0..NUM_REGS-1 (o_reg_send=1), then memory words 0..NUM_MEM-1 (o_mem_send=1), DATA_WIDTH/8 bytes each, then return to IDLE.
REQ-026 Each dump word SHALL be latched one cycle after its select is driven; one o_tx_start per byte; next byte not started before i_tx_done.
REQ-027 Received bytes during DUMP SHALL be discarded.
REQ-028 Select indices SHALL not wrap within a dump; dump ends after last index.

Reset
REQ-029 i_reset=0 SHALL immediately force IDLE, all outputs 0, load address 0, breakpoint 0 and disabled, byte counters 0, including mid-load, mid-run or mid-dump.
REQ-030 After reset release, first valid command SHALL be accepted on first active clock edge.

Verification
REQ-031 Send 4C 13 00 22 20 -> one-cycle o_loading, o_instruccion=0x20220013, o_address=0; repeat -> o_address=4.
REQ-032 Send 52, i_finish=1 after 10 cycles -> o_start high 10 cycles, then 4+4*NUM_REGS+4*NUM_MEM tx bytes in order, o_reg_send/o_mem_send windows correct.
REQ-033 Send 42 08 00 00 00 then 52, i_pc reaches 0x8 -> o_start low next cycle, dump first bytes 08 00 00 00.
REQ-034 Send 53 -> single o_step pulse, full dump; byte 0x7F -> no response.
REQ-035 Assert i_reset mid-dump and after two LOAD bytes -> outputs 0, IDLE; next 4C + 4 bytes loads at address 0.
REQ-036 Hold i_tx_done low 100 cycles -> o_tx_byte stable, no further o_tx_start.

Source files
------------

// File: rtl/debug_ctrl.sv
// Byte-command debug controller: program load, breakpoint, run/step/halt, and a little-endian PC/register/memory dump.
// Commands take effect on the edge after i_rx_valid; each dump byte waits for i_tx_done before the next o_tx_start.
module debug_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_MEM    = 16
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_rx_valid,
    input  logic [7:0]                  i_rx_byte,
    input  logic                        i_tx_done,
    output logic                        o_tx_start,
    output logic [7:0]                  o_tx_byte,
    input  logic                        i_finish,
    input  logic [DATA_WIDTH-1:0]       i_pc,
    input  logic [DATA_WIDTH-1:0]       i_reg,
    input  logic [DATA_WIDTH-1:0]       i_mem,
    output logic [$clog2(NUM_REGS)-1:0] o_reg_sel,
    output logic [$clog2(NUM_MEM)-1:0]  o_mem_sel,
    output logic [DATA_WIDTH-1:0]       o_instruccion,
    output logic [DATA_WIDTH-1:0]       o_address,
    output logic                        o_loading,
    output logic                        o_start,
    output logic                        o_step,
    output logic                        o_reg_send,
    output logic                        o_mem_send
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int RSW = $clog2(NUM_REGS);
    localparam int MSW = $clog2(NUM_MEM);

    typedef enum logic [2:0] {IDLE, LOAD, BKPT, RUN, DUMP} state_t;
    typedef enum logic [1:0] {PH_PC, PH_REG, PH_MEM} phase_t;

    state_t                state, state_nxt;
    phase_t                phase;
    logic                  ds_wait;
    logic [CW-1:0]         rx_cnt, tx_cnt;
    logic [DATA_WIDTH-1:0] col, load_addr, bkpt, shreg;
    logic                  bkpt_en;

    logic [DATA_WIDTH-1:0] assembled, src;
    logic                  rx_last, word_last, dump_last, bkpt_hit;

    always_comb begin
        assembled = (col >> 8) | (DATA_WIDTH'(i_rx_byte) << (DATA_WIDTH - 8));
        rx_last   = i_rx_valid && (rx_cnt == CW'(NB - 1));
        bkpt_hit  = bkpt_en && (i_pc == bkpt);
        word_last = ds_wait && i_tx_done && (tx_cnt == CW'(NB - 1));
        dump_last = word_last && (phase == PH_MEM) && (o_mem_sel == MSW'(NUM_MEM - 1));
        src       = (phase == PH_PC) ? i_pc : (phase == PH_REG) ? i_reg : i_mem;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        o_start    = 1'b0;
        o_reg_send = 1'b0;
        o_mem_send = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_byte)
                        8'h4C:   state_nxt = LOAD;
                        8'h42:   state_nxt = BKPT;
                        8'h52:   state_nxt = i_finish ? DUMP : RUN;
                        8'h53:   state_nxt = DUMP;
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            LOAD, BKPT: begin
                if (rx_last) state_nxt = IDLE;
            end
            RUN: begin
                o_start = 1'b1;
                if (i_finish || bkpt_hit || (i_rx_valid && i_rx_byte == 8'h48))
                    state_nxt = DUMP;
            end
            DUMP: begin
                o_reg_send = (phase == PH_REG);
                o_mem_send = (phase == PH_MEM);
                if (dump_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            phase         <= PH_PC;
            ds_wait       <= 1'b0;
            rx_cnt        <= '0;
            tx_cnt        <= '0;
            col           <= '0;
            load_addr     <= '0;
            bkpt          <= '0;
            bkpt_en       <= 1'b0;
            shreg         <= '0;
            o_reg_sel     <= '0;
            o_mem_sel     <= '0;
            o_tx_start    <= 1'b0;
            o_tx_byte     <= '0;
            o_instruccion <= '0;
            o_address     <= '0;
            o_loading     <= 1'b0;
            o_step        <= 1'b0;
        end else begin
            o_loading     <= 1'b0;
            o_instruccion <= '0;
            o_address     <= '0;
            o_step        <= 1'b0;
            o_tx_start    <= 1'b0;

            if (state == IDLE && i_rx_valid) begin
                case (i_rx_byte)
                    8'h5A:   load_addr <= '0;
                    8'h43:   bkpt_en   <= 1'b0;
                    8'h53:   o_step    <= !i_finish;
                    default: ;
                endcase
            end

            if ((state == LOAD || state == BKPT) && i_rx_valid) begin
                col    <= assembled;
                rx_cnt <= rx_last ? '0 : rx_cnt + CW'(1);
                if (rx_last && state == LOAD) begin
                    o_loading     <= 1'b1;
                    o_instruccion <= assembled;
                    o_address     <= load_addr;
                    load_addr     <= load_addr + DATA_WIDTH'(NB);
                end
                if (rx_last && state == BKPT) begin
                    bkpt    <= assembled;
                    bkpt_en <= 1'b1;
                end
            end

            // Dump bookkeeping idles at PC/index 0 so every dump starts clean.
            if (state != DUMP) begin
                phase     <= PH_PC;
                ds_wait   <= 1'b0;
                tx_cnt    <= '0;
                o_reg_sel <= '0;
                o_mem_sel <= '0;
                o_tx_byte <= '0;
            end else if (!ds_wait) begin
                shreg      <= src >> 8;
                o_tx_byte  <= src[7:0];
                o_tx_start <= 1'b1;
                ds_wait    <= 1'b1;
                tx_cnt     <= '0;
            end else if (i_tx_done) begin
                if (!word_last) begin
                    o_tx_byte  <= shreg[7:0];
                    shreg      <= shreg >> 8;
                    o_tx_start <= 1'b1;
                    tx_cnt     <= tx_cnt + CW'(1);
                end else begin
                    ds_wait <= 1'b0;
                    tx_cnt  <= '0;
                    case (phase)
                        PH_PC:  phase <= PH_REG;
                        PH_REG: begin
                            if (o_reg_sel == RSW'(NUM_REGS - 1)) phase <= PH_MEM;
                            else                                 o_reg_sel <= o_reg_sel + RSW'(1);
                        end
                        PH_MEM: begin
                            if (o_mem_sel != MSW'(NUM_MEM - 1)) o_mem_sel <= o_mem_sel + MSW'(1);
                        end
                        default: phase <= PH_PC;
                    endcase
                end
            end
        end
    end

endmodule
